// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle main FSM and the shared datapath.
// master: the controller (drives per-cycle controls, reads decoded fields).
// slave : the datapath/memory side (drives decoded fields and handshake).
// The perf counter signals exist only when MULTICYCLE_PERF_EN is defined.
interface multicycle_ctrl_if;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic        cond_ok;
  logic        mem_ready;
  logic        ir_w;
  logic        pc_w;
  logic        adr_src;
  logic        mem_req;
  logic        mem_w;
  logic        reg_w;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  result_src;
  logic [1:0]  imm_src;
  logic [1:0]  reg_src;
  logic [2:0]  alu_control;
  logic [1:0]  flag_w;
  logic        mem_err;
  logic [3:0]  state;
`ifdef MULTICYCLE_PERF_EN
  logic [31:0] retired;
  logic [31:0] stall_cyc;

  modport master (
    input  op, funct, rd, cond_ok, mem_ready,
    output ir_w, pc_w, adr_src, mem_req, mem_w, reg_w, alu_src_a, alu_src_b,
           result_src, imm_src, reg_src, alu_control, flag_w, mem_err, state,
           retired, stall_cyc
  );
  modport slave (
    output op, funct, rd, cond_ok, mem_ready,
    input  ir_w, pc_w, adr_src, mem_req, mem_w, reg_w, alu_src_a, alu_src_b,
           result_src, imm_src, reg_src, alu_control, flag_w, mem_err, state,
           retired, stall_cyc
  );
`else
  modport master (
    input  op, funct, rd, cond_ok, mem_ready,
    output ir_w, pc_w, adr_src, mem_req, mem_w, reg_w, alu_src_a, alu_src_b,
           result_src, imm_src, reg_src, alu_control, flag_w, mem_err, state
  );
  modport slave (
    output op, funct, rd, cond_ok, mem_ready,
    input  ir_w, pc_w, adr_src, mem_req, mem_w, reg_w, alu_src_a, alu_src_b,
           result_src, imm_src, reg_src, alu_control, flag_w, mem_err, state
  );
`endif
endinterface

// File: rtl/multicycle_ctrl.sv
// Main FSM of the multicycle CPU: sequences fetch/decode/execute/memory/
// writeback over one shared ALU/memory datapath. Memory accesses wait on
// mem_ready and abort to FETCH with a mem_err pulse after MAX_WAIT stalls.
// Controls are a Moore function of state (plus decoded fields, cond_ok and
// the handshake) and are forced to 0 while rst_n is low.
// Optional: define MULTICYCLE_PERF_EN for retired/stall_cyc counters.
module multicycle_ctrl #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned WAIT_W   = 8
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4, S_MEMWR  = 4'd5, S_EXECR  = 4'd6, S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8, S_BRANCH = 4'd9
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        cmd_s;
  logic [2:0]        exec_alu_s;
  logic              mem_act_s, mem_wait_s, timeout_s, no_write_s;

  logic        ir_w_s, pc_w_s, adr_src_s, mem_req_s, mem_w_s, reg_w_s, mem_err_s;
  logic [1:0]  alu_src_a_s, alu_src_b_s, result_src_s, imm_src_s, reg_src_s, flag_w_s;
  logic [2:0]  alu_control_s;

  function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      4'b0100: alu_decode = 3'b000;
      4'b0010: alu_decode = 3'b001;
      4'b1010: alu_decode = 3'b001;
      4'b1011: alu_decode = 3'b000;
      4'b0000: alu_decode = 3'b010;
      4'b1000: alu_decode = 3'b010;
      4'b1100: alu_decode = 3'b011;
      default: alu_decode = 3'b000;
    endcase
  endfunction

  assign cmd_s      = bus.funct[4:1];
  assign exec_alu_s = alu_decode(cmd_s);
  // cmp, cmn and tst only update flags and never reach ALUWB
  assign no_write_s = (cmd_s == 4'b1010) || (cmd_s == 4'b1011) || (cmd_s == 4'b1000);
  // A store with a failed condition never touches memory, so it cannot stall
  assign mem_act_s  = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                      ((state_q == S_MEMWR) && bus.cond_ok);
  assign mem_wait_s = mem_act_s && !bus.mem_ready;
  assign timeout_s  = mem_wait_s && (wait_q == WAIT_W'(MAX_WAIT));

  // State register and memory wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state selection and wait counter update
  always_comb begin
    state_d = state_q;
    if (mem_wait_s && !timeout_s) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
    end
    if (timeout_s) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (bus.op)
            2'd0:    state_d = bus.funct[5] ? S_EXECI : S_EXECR;
            2'd1:    state_d = S_MEMADR;
            2'd2:    state_d = S_BRANCH;
            default: state_d = S_FETCH;
          endcase
        end
        S_MEMADR: state_d = bus.funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWB:  state_d = S_FETCH;
        S_MEMWR:  state_d = (!bus.cond_ok || bus.mem_ready) ? S_FETCH : S_MEMWR;
        S_EXECR,
        S_EXECI:  state_d = no_write_s ? S_FETCH : S_ALUWB;
        S_ALUWB:  state_d = S_FETCH;
        S_BRANCH: state_d = S_FETCH;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  // Per-state datapath controls
  always_comb begin
    ir_w_s = 1'b0; pc_w_s = 1'b0; adr_src_s = 1'b0; mem_req_s = 1'b0;
    mem_w_s = 1'b0; reg_w_s = 1'b0; mem_err_s = 1'b0;
    alu_src_a_s = 2'd0; alu_src_b_s = 2'd0; result_src_s = 2'd0;
    imm_src_s = 2'd0; reg_src_s = 2'd0; flag_w_s = 2'b00; alu_control_s = 3'b000;
    if (!rst_n) begin
      mem_err_s = 1'b0;
    end else begin
      mem_err_s = timeout_s;
      // Immediate and register-source selects follow op for the whole instruction
      if ((state_q != S_FETCH) && (state_q <= S_BRANCH)) begin
        case (bus.op)
          2'd1:    imm_src_s = 2'd1;
          2'd2:    imm_src_s = 2'd2;
          default: imm_src_s = 2'd0;
        endcase
        reg_src_s = {bus.op == 2'd1, bus.op == 2'd2};
      end else begin
        imm_src_s = 2'd0;
      end
      case (state_q)
        S_FETCH: begin
          mem_req_s    = !timeout_s;
          alu_src_a_s  = 2'd1;
          alu_src_b_s  = 2'd2;
          result_src_s = 2'd2;
          ir_w_s       = bus.mem_ready;
          pc_w_s       = bus.mem_ready;
        end
        S_DECODE: begin
          alu_src_a_s = 2'd1;
          alu_src_b_s = 2'd2;
        end
        S_MEMADR: alu_src_b_s = 2'd1;
        S_MEMRD: begin
          mem_req_s = !timeout_s;
          adr_src_s = 1'b1;
        end
        S_MEMWB: begin
          result_src_s = 2'd1;
          reg_w_s      = bus.cond_ok;
          pc_w_s       = bus.cond_ok && (bus.rd == 4'd15);
        end
        S_MEMWR: begin
          mem_req_s = bus.cond_ok && !timeout_s;
          mem_w_s   = bus.cond_ok && !timeout_s;
          adr_src_s = 1'b1;
        end
        S_EXECR, S_EXECI: begin
          alu_src_b_s   = (state_q == S_EXECI) ? 2'd1 : 2'd0;
          alu_control_s = exec_alu_s;
          flag_w_s[1]   = bus.funct[0] && bus.cond_ok;
          flag_w_s[0]   = flag_w_s[1] && (exec_alu_s[2:1] == 2'b00);
        end
        S_ALUWB: begin
          pc_w_s  = bus.cond_ok && (bus.rd == 4'd15);
          reg_w_s = bus.cond_ok && (bus.rd != 4'd15);
        end
        S_BRANCH: begin
          alu_src_a_s  = 2'd2;
          alu_src_b_s  = 2'd1;
          result_src_s = 2'd2;
          pc_w_s       = bus.cond_ok;
        end
        default: mem_req_s = 1'b0;
      endcase
    end
  end

  assign bus.ir_w        = ir_w_s;
  assign bus.pc_w        = pc_w_s;
  assign bus.adr_src     = adr_src_s;
  assign bus.mem_req     = mem_req_s;
  assign bus.mem_w       = mem_w_s;
  assign bus.reg_w       = reg_w_s;
  assign bus.alu_src_a   = alu_src_a_s;
  assign bus.alu_src_b   = alu_src_b_s;
  assign bus.result_src  = result_src_s;
  assign bus.imm_src     = imm_src_s;
  assign bus.reg_src     = reg_src_s;
  assign bus.alu_control = alu_control_s;
  assign bus.flag_w      = flag_w_s;
  assign bus.mem_err     = mem_err_s;
  assign bus.state       = state_q;

`ifdef MULTICYCLE_PERF_EN
  logic [31:0] retired_q, retired_d, stall_q, stall_d;
  logic        retire_s;

  // An instruction retires when any state other than FETCH returns to FETCH normally
  assign retire_s  = (state_d == S_FETCH) && (state_q != S_FETCH) && !timeout_s;
  assign retired_d = retire_s   ? retired_q + 32'd1 : retired_q;
  assign stall_d   = mem_wait_s ? stall_q + 32'd1   : stall_q;

  // Retired-instruction and memory-stall counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.retired   = retired_q;
  assign bus.stall_cyc = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl (MAX_WAIT = 4): reset values, a table of
// zero-wait instructions (latency and pulse counts), hand-written wait,
// timeout and mid-access reset sequences, and random instructions checked
// cycle by cycle against an instruction-level trace model.
module tb_multicycle_ctrl;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst_n;
  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MAX_WAIT(MW), .WAIT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // One expected cycle: stimulus mem_ready plus the observed controls
  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic       ir, pc, rw, mw, me, mq;
    logic [1:0] fl;
    logic [2:0] alu;
  } cyc_t;
  cyc_t plan[$];

  typedef struct {
    logic [1:0] op; logic [5:0] f; logic [3:0] rd; logic c;
    int cyc; int nrw; int npc; int nmw; logic [1:0] fl;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [2:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: alu_of = 3'b001;
      4'b0000, 4'b1000: alu_of = 3'b010;
      4'b1100:          alu_of = 3'b011;
      default:          alu_of = 3'b000;
    endcase
  endfunction

  function automatic bit no_wr(input logic [3:0] cmd);
    return (cmd == 4'b1010) || (cmd == 4'b1011) || (cmd == 4'b1000);
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic ir, input logic pc,
                      input logic rw, input logic mw, input logic me, input logic mq,
                      input logic [1:0] fl, input logic [2:0] alu);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.ir = ir; c.pc = pc; c.rw = rw; c.mw = mw;
    c.me = me; c.mq = mq; c.fl = fl; c.alu = alu;
    plan.push_back(c);
  endtask

  // Expected per-cycle trace of one instruction: fw fetch stalls, mw memory
  // stalls, mto = memory access times out, fto = fetch times out
  task automatic build(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                       input logic c, input int fw, input int mw, input bit mto, input bit fto);
    logic [3:0] cmd;
    logic       s;
    int         w;
    cmd = f[4:1];
    s   = f[0] & c;
    w   = mto ? MW : mw;
    plan.delete();
    if (fto) begin
      for (int i = 0; i < MW; i++) push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
      push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000);
      return;
    end
    for (int i = 0; i < fw; i++) push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
    push(4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
    push(4'd1, rnd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
    case (op)
      2'd0: begin
        push(f[5] ? 4'd7 : 4'd6, rnd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             {s, s & (alu_of(cmd) == 3'b000 || alu_of(cmd) == 3'b001)}, alu_of(cmd));
        if (!no_wr(cmd))
          push(4'd8, rnd(), 1'b0, c && rd == 4'd15, c && rd != 4'd15, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
      end
      2'd1: begin
        push(4'd2, rnd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
        if (f[0]) begin
          for (int i = 0; i < w; i++) push(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
          if (mto) push(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000);
          else begin
            push(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
            push(4'd4, rnd(), 1'b0, c && rd == 4'd15, c, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
          end
        end else if (!c) begin
          push(4'd5, rnd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
        end else begin
          for (int i = 0; i < w; i++) push(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b000);
          if (mto) push(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000);
          else     push(4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b000);
        end
      end
      2'd2: push(4'd9, rnd(), 1'b0, c, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
      default: ;
    endcase
  endtask

  // Drive the planned instruction from FETCH and compare every cycle
  task automatic run_plan(input string tag, input logic [1:0] op, input logic [5:0] f,
                          input logic [3:0] rd, input logic c);
    logic [14:0] act, exp;
    bus.op = op; bus.funct = f; bus.rd = rd; bus.cond_ok = c;
    for (int i = 0; i < plan.size(); i++) begin
      bus.mem_ready = plan[i].rdy;
      @(negedge clk);
      act = {bus.state, bus.ir_w, bus.pc_w, bus.reg_w, bus.mem_w, bus.mem_err,
             bus.mem_req, bus.flag_w, bus.alu_control};
      exp = {plan[i].st, plan[i].ir, plan[i].pc, plan[i].rw, plan[i].mw, plan[i].me,
             plan[i].mq, plan[i].fl, plan[i].alu};
      check($sformatf("%s op%0d f%b step%0d", tag, op, f, i), {17'd0, act}, {17'd0, exp});
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, nrw, npc, nmw;
    logic [1:0] fl, op;
    logic [5:0] f;
    logic [3:0] rd;
    logic       c;
    int fw, mw;
    bit mto, fto;

    //        op    funct       rd     c     cyc rw pc mw flags
    tbl[0]  = '{2'd0, 6'b001000, 4'd1,  1'b1, 4, 1, 1, 0, 2'b00}; // add
    tbl[1]  = '{2'd0, 6'b101001, 4'd2,  1'b1, 4, 1, 1, 0, 2'b11}; // adds imm
    tbl[2]  = '{2'd0, 6'b010101, 4'd0,  1'b1, 3, 0, 1, 0, 2'b11}; // cmp
    tbl[3]  = '{2'd0, 6'b000001, 4'd3,  1'b1, 4, 1, 1, 0, 2'b10}; // ands
    tbl[4]  = '{2'd0, 6'b011000, 4'd15, 1'b1, 4, 0, 2, 0, 2'b00}; // orr pc
    tbl[5]  = '{2'd0, 6'b000101, 4'd1,  1'b0, 4, 0, 1, 0, 2'b00}; // subs, cond fail
    tbl[6]  = '{2'd1, 6'b011001, 4'd4,  1'b1, 5, 1, 1, 0, 2'b00}; // ldr
    tbl[7]  = '{2'd1, 6'b011001, 4'd15, 1'b1, 5, 1, 2, 0, 2'b00}; // ldr pc
    tbl[8]  = '{2'd1, 6'b011000, 4'd4,  1'b1, 4, 0, 1, 1, 2'b00}; // str
    tbl[9]  = '{2'd1, 6'b011000, 4'd4,  1'b0, 4, 0, 1, 0, 2'b00}; // str, cond fail
    tbl[10] = '{2'd2, 6'b100000, 4'd0,  1'b1, 3, 0, 2, 0, 2'b00}; // b
    tbl[11] = '{2'd2, 6'b100000, 4'd0,  1'b0, 3, 0, 1, 0, 2'b00}; // b, cond fail
    tbl[12] = '{2'd3, 6'b000000, 4'd0,  1'b1, 2, 0, 1, 0, 2'b00}; // undefined: nop
    tbl[13] = '{2'd0, 6'b010001, 4'd0,  1'b1, 3, 0, 1, 0, 2'b10}; // tst

    rst_n = 1'b0;
    bus.op = 2'd0; bus.funct = 6'd0; bus.rd = 4'd0; bus.cond_ok = 1'b1; bus.mem_ready = 1'b1;
    #12;
    check("reset outputs",
          {6'd0, bus.ir_w, bus.pc_w, bus.adr_src, bus.mem_req, bus.mem_w, bus.reg_w,
           bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.imm_src, bus.reg_src,
           bus.alu_control, bus.flag_w, bus.mem_err, bus.state}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("fetch mem_req after reset", {31'd0, bus.mem_req}, 32'd1);

    // Zero-wait latency and write-pulse table
    for (int i = 0; i < 14; i++) begin
      bus.op = tbl[i].op; bus.funct = tbl[i].f; bus.rd = tbl[i].rd;
      bus.cond_ok = tbl[i].c; bus.mem_ready = 1'b1;
      cyc = 0; nrw = 0; npc = 0; nmw = 0; fl = 2'b00;
      do begin
        @(negedge clk);
        nrw += int'(bus.reg_w); npc += int'(bus.pc_w); nmw += int'(bus.mem_w);
        fl |= bus.flag_w;
        cyc++;
        @(posedge clk); #1;
      end while (bus.state != 4'd0 && cyc < 20);
      check($sformatf("tbl%0d cycles", i), cyc, tbl[i].cyc);
      check($sformatf("tbl%0d rw/pc/mw/flags", i), {nrw[7:0], npc[7:0], nmw[7:0], 6'd0, fl},
            {tbl[i].nrw[7:0], tbl[i].npc[7:0], tbl[i].nmw[7:0], 6'd0, tbl[i].fl});
    end

    // ldr with three memory stall cycles
    build(2'd1, 6'b011001, 4'd4, 1'b1, 0, 3, 1'b0, 1'b0);
    run_plan("ldr3w", 2'd1, 6'b011001, 4'd4, 1'b1);
    // str with mem_ready stuck low: timeout
    build(2'd1, 6'b011000, 4'd4, 1'b1, 0, 0, 1'b1, 1'b0);
    run_plan("strto", 2'd1, 6'b011000, 4'd4, 1'b1);
    // fetch timeout
    build(2'd0, 6'b001000, 4'd1, 1'b1, 0, 0, 1'b0, 1'b1);
    run_plan("fetchto", 2'd0, 6'b001000, 4'd1, 1'b1);

    // Reset asserted in the middle of a stalled store
    bus.op = 2'd1; bus.funct = 6'b011000; bus.rd = 4'd4; bus.cond_ok = 1'b1; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    check("memwr before reset", {26'd0, bus.state, bus.mem_w, bus.mem_req}, {26'd0, 4'd5, 1'b1, 1'b1});
    rst_n = 1'b0;
    #1;
    check("async reset in memwr", {26'd0, bus.state, bus.mem_w, bus.mem_req}, 32'd0);
    @(posedge clk); #1;
    check("held reset", {26'd0, bus.state, bus.mem_w, bus.mem_req}, 32'd0);
    rst_n = 1'b1;

    // Random instructions against the trace model
    for (int n = 0; n < 80; n++) begin
      op  = 2'($urandom_range(0, 3));
      f   = 6'($urandom);
      rd  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      c   = ($urandom_range(0, 3) != 0);
      fw  = $urandom_range(0, 2);
      mw  = $urandom_range(0, MW);
      mto = ($urandom_range(0, 5) == 0);
      fto = ($urandom_range(0, 19) == 0);
      build(op, f, rd, c, fw, mw, mto, fto);
      run_plan($sformatf("rnd%0d", n), op, f, rd, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main FSM for the multicycle build of the CPU. It sequences one shared ALU/memory datapath through fetch, decode, execute, memory and writeback steps.
- Per-cycle instruction-class controls come from the same op/funct/rd fields the single-cycle decoder uses.
- Memory accesses are held with a ready handshake, bounded by a wait timeout.
- Architectural writes are gated by the condition-check result.

Parameters:
MAX_WAIT, 255, maximum cycles a memory access may stall before abort (1..255)
WAIT_W, 8, width of wait counter; must hold MAX_WAIT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  2  instr[27:26]; 0 data-proc, 1 ldr/str, 2 branch, 3 undefined
funct  in  6  instr[25:20]; [5] immediate, [4:1] cmd, [0] S / L bit
rd  in  4  instr[15:12]
cond_ok  in  1  condition check on current flags, valid from DECODE onward
mem_ready  in  1  memory completes current access this cycle
ir_w  out  1  latch fetched word into IR
pc_w  out  1  write PC
adr_src  out  1  0 = PC, 1 = ALU result register drives memory address
mem_req  out  1  memory access active
mem_w  out  1  memory write strobe (qualified by mem_req)
reg_w  out  1  register file write
alu_src_a  out  2  0 Rn, 1 PC, 2 ALU result reg
alu_src_b  out  2  0 Rm, 1 ext imm, 2 constant 4
result_src  out  2  0 ALU result reg, 1 read data, 2 ALU direct
imm_src  out  2  0 dp imm8, 1 mem imm12, 2 branch imm24
reg_src  out  2  [0] Rn := PC(15) for branch, [1] Rm := Rd for str
alu_control  out  3  000 add, 001 sub, 010 and, 011 or
flag_w  out  2  [1] NZ write, [0] CV write
mem_err  out  1  one-cycle pulse on wait timeout
state  out  4  current state encoding, for debug

Behaviour:
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9.
- Reset: async on rst_n low → state = FETCH, wait counter = 0. All outputs are 0 except `state` = 0.
- Outputs are a Moore function of state, plus the decoded fields and cond_ok where noted. Idle value of every output is 0.
- FETCH:
  - mem_req = 1, adr_src = 0, alu_src_a = 1, alu_src_b = 2, alu_control = 000, result_src = 2.
  - While mem_ready = 0: stay in FETCH, increment wait counter.
  - When mem_ready = 1: ir_w = 1, pc_w = 1 (PC += 4), wait counter := 0, next state DECODE.
- DECODE:
  - alu_src_a = 1, alu_src_b = 2, alu_control = 000 (forms PC + 8).
  - imm_src and reg_src are driven from op for the whole instruction.
  - Next state by op:
    - op 0, funct[5] = 0 → EXECR
    - op 0, funct[5] = 1 → EXECI
    - op 1 → MEMADR
    - op 2 → BRANCH
    - op 3 → FETCH (NOP)
- MEMADR:
  - alu_src_b = 1, alu_control = 000.
  - Next state: funct[0] = 1 → MEMRD; funct[0] = 0 → MEMWR.
- MEMRD:
  - mem_req = 1, adr_src = 1.
  - Wait on mem_ready as in FETCH; on mem_ready = 1 → MEMWB.
- MEMWB:
  - result_src = 1, reg_w = cond_ok.
  - If rd = 15: pc_w = cond_ok as well.
  - Next state FETCH.
- MEMWR:
  - mem_req = 1, adr_src = 1, mem_w = cond_ok.
  - Wait on mem_ready; on mem_ready = 1 → FETCH.
  - If cond_ok = 0: skip memory, go directly to FETCH.
- EXECR / EXECI:
  - alu_src_b = 0 (EXECR) or 1 (EXECI).
  - alu_control from cmd:
    - 0100 → 000
    - 0010 → 001
    - 1010 (cmp) → 001
    - 1011 (cmn) → 000
    - 0000 → 010
    - 1000 (tst) → 010
    - 1100 → 011
    - any other cmd → 000
  - flag_w[1] = funct[0] & cond_ok.
  - flag_w[0] = flag_w[1] & (alu_control is 000 or 001).
  - Next state: cmd in {1010, 1011, 1000} (no-write ops) → FETCH; otherwise → ALUWB.
- ALUWB:
  - result_src = 0, reg_w = cond_ok.
  - If rd = 15: pc_w = cond_ok, no reg_w.
  - Next state FETCH.
- BRANCH:
  - alu_src_a = 2, alu_src_b = 1, alu_control = 000, result_src = 2, pc_w = cond_ok.
  - Next state FETCH.
- Timeout: if the wait counter reaches MAX_WAIT while mem_ready = 0 in FETCH, MEMRD or MEMWR:
  - mem_err pulses for 1 cycle, mem_req drops, counter clears, next state FETCH.
  - No ir_w, reg_w or pc_w is asserted.
- mem_ready outside a memory state is ignored.
- rst_n asserted mid-access aborts immediately; no write strobe is held.
- Instruction latency: dp 4 cycles (3 for no-write ops), ldr 5, str 4, b 3, each with zero wait states.

Optional Feature:
MULTICYCLE_PERF_EN: adds outputs retired[31:0] and stall_cyc[31:0].
- retired increments on each transition into FETCH from a completing state; timeout aborts are not counted.
- stall_cyc increments each cycle a memory state sees mem_ready = 0.
- Both counters reset to 0 on rst_n and wrap at 2^32.
- Without the macro these ports do not exist and there is no counter logic.

Test Plan:
- add r1,r2,r3 (op 0, funct 001000), mem_ready held 1 → states 0,1,6,8,0; reg_w = 1 only in ALUWB; alu_control = 000 in EXECR.
- ldr r4,[r0,#4] with mem_ready low for 3 cycles in MEMRD → MEMRD lasts 4 cycles; reg_w in MEMWB; total 8 cycles.
- cmp (funct 010101) → flag_w = 11 in EXECR; returns directly to FETCH; reg_w never asserted.
- b with cond_ok = 0 → pc_w low in BRANCH; PC advanced only by the fetch.
- str with mem_ready stuck 0, MAX_WAIT = 4 → mem_err pulses once after 4 wait cycles; mem_w drops; next state FETCH.
- rst_n low during MEMWR → next edge has state 0; mem_req = 0 and mem_w = 0 asynchronously.
